// File: rtl/toy_phy_reg_freelist_pkg.sv
// Shared rename-side constants and the physical register ID type.
package toy_pack;

    localparam int unsigned INST_DECODE_NUM  = 4;
    localparam int unsigned ARCH_REG_NUM     = 32;
    localparam int unsigned PHY_REG_NUM_DEF  = 64;
    localparam int unsigned PHY_REG_ID_WIDTH = $clog2(PHY_REG_NUM_DEF);

    typedef logic [PHY_REG_ID_WIDTH-1:0] phy_id_t;

endpackage

// File: rtl/toy_phy_reg_freelist_popcnt_prefix.sv
// Exclusive prefix popcount: prefix[i] = number of set bits in bits[i-1:0].
module toy_popcnt_prefix #(
    parameter int unsigned N = 4,
    localparam int unsigned CW = $clog2(N + 1)
) (
    input  logic [N-1:0]         bits,
    output logic [N-1:0][CW-1:0] prefix
);

    logic [CW-1:0] acc;

    // Running sum; each lane sees the count of the lanes strictly below it.
    always_comb begin
        acc    = '0;
        prefix = '0;
        for (int unsigned i = 0; i < N; i++) begin
            prefix[i] = acc;
            acc       = acc + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/toy_phy_reg_freelist.sv
// Physical register free list: circular buffer of free IDs offered to the
// decode lanes and refilled by commit releases.
// Optional double-free checker enabled by defining TOY_FREELIST_CHECK_EN.
module toy_phy_reg_freelist
    import toy_pack::phy_id_t;
    import toy_pack::INST_DECODE_NUM;
    import toy_pack::PHY_REG_ID_WIDTH;
#(
    parameter int unsigned LANE_NUM     = INST_DECODE_NUM,
    parameter int unsigned REL_NUM      = 4,
    parameter int unsigned PHY_REG_NUM  = 64,
    parameter int unsigned ARCH_REG_NUM = toy_pack::ARCH_REG_NUM,
    localparam int unsigned FL_DEPTH    = PHY_REG_NUM - ARCH_REG_NUM,
    localparam int unsigned PW          = $clog2(FL_DEPTH),
    localparam int unsigned CNTW        = PW + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic    [LANE_NUM-1:0]      v_alloc_req,
    input  logic    [LANE_NUM-1:0]      v_alloc_zero,
    output logic    [LANE_NUM-1:0]      v_pre_allocate_vld,
    output phy_id_t [LANE_NUM-1:0]      v_pre_allocate_id,
    input  logic    [LANE_NUM-1:0]      v_pre_allocate_rdy,
    input  logic    [REL_NUM-1:0]       v_release_vld,
    input  phy_id_t [REL_NUM-1:0]       v_release_id,
    output logic    [CNTW-1:0]          free_cnt,
    output logic                        err_double_free
);

    localparam int unsigned LCW = $clog2(LANE_NUM + 1);
    localparam int unsigned RCW = $clog2(REL_NUM + 1);

    phy_id_t                      fl_mem [FL_DEPTH];
    logic    [PW-1:0]             head;
    logic    [PW-1:0]             tail;

    logic    [LANE_NUM-1:0]       nz_req;
    logic    [LANE_NUM-1:0]       grant;
    logic    [LANE_NUM-1:0][LCW-1:0] req_pfx;
    logic    [LANE_NUM-1:0][LCW-1:0] gnt_pfx;
    logic    [LANE_NUM-1:0][CNTW-1:0] req_incl;
    logic    [LCW-1:0]            pop_n;

    logic    [REL_NUM-1:0]        rel_acc;
    logic    [REL_NUM-1:0][RCW-1:0] rel_pfx;
    logic    [RCW-1:0]            push_n;

    assign nz_req = v_alloc_req & ~v_alloc_zero;
    assign grant  = v_pre_allocate_rdy & nz_req;

    toy_popcnt_prefix #(.N(LANE_NUM)) u_req_pfx (.bits(nz_req),  .prefix(req_pfx));
    toy_popcnt_prefix #(.N(LANE_NUM)) u_gnt_pfx (.bits(grant),   .prefix(gnt_pfx));
    toy_popcnt_prefix #(.N(REL_NUM))  u_rel_pfx (.bits(rel_acc), .prefix(rel_pfx));

    assign pop_n  = gnt_pfx[LANE_NUM-1] + LCW'(grant[LANE_NUM-1]);
    assign push_n = rel_pfx[REL_NUM-1] + RCW'(rel_acc[REL_NUM-1]);

    // Lane offers: vld depends only on requests, id only on earlier grants.
    always_comb begin
        req_incl           = '0;
        v_pre_allocate_vld = '0;
        v_pre_allocate_id  = '0;
        for (int unsigned i = 0; i < LANE_NUM; i++) begin
            req_incl[i]           = CNTW'(req_pfx[i]) + CNTW'(nz_req[i]);
            v_pre_allocate_vld[i] = v_alloc_zero[i] | (free_cnt >= req_incl[i]);
            v_pre_allocate_id[i]  = v_alloc_zero[i] ? '0
                                  : fl_mem[PW'(head + PW'(gnt_pfx[i]))];
        end
    end

`ifdef TOY_FREELIST_CHECK_EN
    logic [PHY_REG_NUM-1:0] free_map;
    logic [REL_NUM-1:0]     rel_bad;

    // Reject releases of x0, out-of-range IDs, already-free IDs and same-cycle repeats.
    always_comb begin
        rel_acc = '0;
        rel_bad = '0;
        for (int unsigned k = 0; k < REL_NUM; k++) begin
            if (v_release_vld[k]) begin
                rel_bad[k] = (v_release_id[k] == '0)
                           | ({1'b0, v_release_id[k]} >= (PHY_REG_ID_WIDTH + 1)'(PHY_REG_NUM))
                           | free_map[v_release_id[k]];
                for (int unsigned j = 0; j < k; j++) begin
                    if (rel_acc[j] && (v_release_id[j] == v_release_id[k])) begin
                        rel_bad[k] = 1'b1;
                    end
                end
                rel_acc[k] = ~rel_bad[k];
            end
        end
    end

    // Free bitmap tracking and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < PHY_REG_NUM; i++) begin
                free_map[i] <= (i >= ARCH_REG_NUM);
            end
            err_double_free <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < LANE_NUM; i++) begin
                if (grant[i]) begin
                    free_map[v_pre_allocate_id[i]] <= 1'b0;
                end
            end
            for (int unsigned k = 0; k < REL_NUM; k++) begin
                if (rel_acc[k]) begin
                    free_map[v_release_id[k]] <= 1'b1;
                end
            end
            if (|rel_bad) begin
                err_double_free <= 1'b1;
            end
        end
    end
`else
    assign rel_acc         = v_release_vld;
    assign err_double_free = 1'b0;
`endif

    // Buffer storage, pointers and free count; pops read pre-update contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FL_DEPTH; i++) begin
                fl_mem[i] <= phy_id_t'(ARCH_REG_NUM + i);
            end
            head     <= '0;
            tail     <= '0;
            free_cnt <= CNTW'(FL_DEPTH);
        end else begin
            for (int unsigned k = 0; k < REL_NUM; k++) begin
                if (rel_acc[k]) begin
                    fl_mem[PW'(tail + PW'(rel_pfx[k]))] <= v_release_id[k];
                end
            end
            head     <= head + PW'(pop_n);
            tail     <= tail + PW'(push_n);
            free_cnt <= free_cnt - CNTW'(pop_n) + CNTW'(push_n);
        end
    end

endmodule

// File: tb/tb_toy_phy_reg_freelist.sv
// Self-checking bench for toy_phy_reg_freelist against a queue-based free-list model.
module tb_toy_phy_reg_freelist;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      req, zero, vld, rdy, rvld;
    logic [3:0][5:0] id, rid;
    logic [5:0]      cnt;
    logic            err;

    int checks   = 0;
    int failures = 0;

    int fl_q[$];     // free IDs in allocation order
    int alloc_q[$];  // IDs currently handed out, eligible for release
    bit exp_err;

    toy_phy_reg_freelist dut (
        .clk                (clk),
        .rst                (rst),
        .v_alloc_req        (req),
        .v_alloc_zero       (zero),
        .v_pre_allocate_vld (vld),
        .v_pre_allocate_id  (id),
        .v_pre_allocate_rdy (rdy),
        .v_release_vld      (rvld),
        .v_release_id       (rid),
        .free_cnt           (cnt),
        .err_double_free    (err)
    );

    always #5 clk = ~clk;

    function automatic bit in_q(input int q[$], input int v);
        foreach (q[i]) if (q[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_reset();
        fl_q.delete();
        alloc_q.delete();
        for (int i = 0; i < 32; i++) fl_q.push_back(32 + i);
        exp_err = 1'b0;
    endfunction

    // One clock of stimulus: check outputs mid-cycle, then advance the model.
    task automatic step(input logic [3:0] a_req, input logic [3:0] a_zero,
                        input logic [3:0] a_rdy, input logic [3:0] a_rvld,
                        input logic [3:0][5:0] a_rid, input string tag);
        logic [3:0] ev;
        int n, g, v;
        int acc[$];
        bit ok;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (a_req[i] && !a_zero[i]) n++;
            ev[i] = a_zero[i] || (fl_q.size() >= n);
        end
        req  = a_req;
        zero = a_zero;
        rdy  = a_rdy & ~(a_req & ~a_zero & ~ev);
        rvld = a_rvld;
        rid  = a_rid;
        @(negedge clk);
        checks++;
        if (vld !== ev) begin
            failures++;
            $display("FAIL %s vld: got %b expected %b", tag, vld, ev);
        end
        checks++;
        if (cnt !== 6'(fl_q.size())) begin
            failures++;
            $display("FAIL %s free_cnt: got %0d expected %0d", tag, cnt, fl_q.size());
        end
        checks++;
        if (err !== exp_err) begin
            failures++;
            $display("FAIL %s err_double_free: got %b expected %b", tag, err, exp_err);
        end
        g = 0;
        for (int i = 0; i < 4; i++) begin
            if (zero[i]) begin
                checks++;
                if (id[i] !== 6'd0) begin
                    failures++;
                    $display("FAIL %s lane%0d zero id: got %0d expected 0", tag, i, id[i]);
                end
            end else if (req[i] && ev[i]) begin
                checks++;
                if (id[i] !== 6'(fl_q[g])) begin
                    failures++;
                    $display("FAIL %s lane%0d id: got %0d expected %0d", tag, i, id[i], fl_q[g]);
                end
                if (rdy[i]) g++;
            end
        end
        @(posedge clk);
        // releases judged against the free set before this cycle's pops
        for (int k = 0; k < 4; k++) begin
            if (rvld[k]) begin
                v  = int'(rid[k]);
                ok = 1'b1;
`ifdef TOY_FREELIST_CHECK_EN
                if (v == 0 || in_q(fl_q, v) || in_q(acc, v)) ok = 1'b0;
`endif
                if (ok) acc.push_back(v);
                else exp_err = 1'b1;
            end
        end
        for (int i = 0; i < g; i++) alloc_q.push_back(fl_q.pop_front());
        foreach (acc[i]) begin
            fl_q.push_back(acc[i]);
            for (int j = alloc_q.size() - 1; j >= 0; j--)
                if (alloc_q[j] == acc[i]) alloc_q.delete(j);
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; zero = '0; rdy = '0; rvld = '0; rid = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'hf; zero = '0; rdy = '0; rvld = '0; rid = '0;
        model_reset();
        @(negedge clk);
        checks++;
        if (cnt !== 6'd32) begin failures++; $display("FAIL reset free_cnt: got %0d expected 32", cnt); end
        checks++;
        if (vld !== 4'hf) begin failures++; $display("FAIL reset vld: got %b expected 1111", vld); end
        checks++;
        if (id[0] !== 6'd32 || id[3] !== 6'd32) begin
            failures++; $display("FAIL reset id: got %0d/%0d expected 32/32", id[0], id[3]);
        end
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL reset err: got %b expected 0", err); end
        rst = 1'b0; req = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_alloc();
        do_reset();
        step(4'b0001, 4'b0000, 4'b0001, 4'b0000, '0, "single_grant");
        step(4'b0001, 4'b0000, 4'b0000, 4'b0000, '0, "single_next");
        checks++;
        if (id[0] !== 6'd33 || cnt !== 6'd31) begin
            failures++; $display("FAIL single_const: got id %0d cnt %0d expected 33/31", id[0], cnt);
        end
    endtask

    task automatic test_out_of_order();
        do_reset();
        step(4'b1111, 4'b0000, 4'b1010, 4'b0000, '0, "ooo_grant");
        step(4'b0001, 4'b0000, 4'b0000, 4'b0000, '0, "ooo_after");
    endtask

    task automatic test_zero_lanes();
        do_reset();
        step(4'b0011, 4'b0010, 4'b0011, 4'b0000, '0, "zero_grant");
        step(4'b0001, 4'b0000, 4'b0000, 4'b0000, '0, "zero_after");
    endtask

    task automatic test_near_empty();
        do_reset();
        for (int i = 0; i < 7; i++) step(4'hf, 4'h0, 4'hf, 4'h0, '0, "drain");
        step(4'b0011, 4'b0000, 4'b0011, 4'h0, '0, "drain2");
        step(4'hf, 4'h0, 4'hf, 4'h0, '0, "near_empty");
        step(4'hf, 4'h0, 4'h0, 4'h0, '0, "empty");
        step(4'hf, 4'b0100, 4'h0, 4'h0, '0, "empty_zero");
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 7; i++) step(4'hf, 4'h0, 4'hf, 4'h0, '0, "wrap_fill");
        step(4'b0011, 4'b0000, 4'b0011, 4'h0, '0, "wrap_fill2");
        step(4'h0, 4'h0, 4'h0, 4'hf, {6'd35, 6'd34, 6'd33, 6'd32}, "wrap_rel");
        step(4'hf, 4'h0, 4'hf, 4'b0011, {6'd0, 6'd0, 6'd41, 6'd40}, "wrap_popush");
        step(4'hf, 4'h0, 4'h0, 4'h0, '0, "wrap_after");
    endtask

    task automatic test_random();
        logic [3:0]      r_rvld;
        logic [3:0][5:0] r_rid;
        int idx;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            r_rvld = '0;
            r_rid  = '0;
            for (int k = 0; k < 4; k++) begin
                if (alloc_q.size() > 0 && $urandom_range(0, 2) != 0) begin
                    idx      = $urandom_range(0, alloc_q.size() - 1);
                    r_rvld[k] = 1'b1;
                    r_rid[k]  = 6'(alloc_q[idx]);
                    alloc_q.delete(idx);
                end
            end
            step(4'($urandom), 4'($urandom) & 4'($urandom), 4'($urandom), r_rvld, r_rid, "random");
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(4'hf, 4'h0, 4'hf, 4'h0, '0, "mid_pre");
        test_reset();
        step(4'b0001, 4'h0, 4'b0001, 4'h0, '0, "mid_post");
    endtask

`ifdef TOY_FREELIST_CHECK_EN
    task automatic test_double_free();
        do_reset();
        for (int i = 0; i < 3; i++) step(4'hf, 4'h0, 4'hf, 4'h0, '0, "df_fill");
        step(4'h0, 4'h0, 4'h0, 4'b0001, {18'd0, 6'd40}, "df_first");
        step(4'h0, 4'h0, 4'h0, 4'b0001, {18'd0, 6'd40}, "df_second");
        for (int i = 0; i < 3; i++) step(4'h0, 4'h0, 4'h0, 4'h0, '0, "df_sticky");
        test_reset();
        step(4'h0, 4'h0, 4'h0, 4'b0001, {18'd0, 6'd0}, "df_zero");
        step(4'h0, 4'h0, 4'h0, 4'h0, '0, "df_zero_after");
    endtask
`endif

    initial begin
        test_reset();
        test_single_alloc();
        test_out_of_order();
        test_zero_lanes();
        test_near_empty();
        test_wrap();
        test_random();
        test_reset_mid();
`ifdef TOY_FREELIST_CHECK_EN
        test_double_free();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
